// File: rtl/ysyx_22050710_rf.sv
// Architectural state bank: x1..x31 plus mstatus/mtvec/mepc/mcause, with ecall/mret side effects.
// Optional same-cycle write-first bypass on all read ports: define YSYX_22050710_RF_BYPASS_EN.
module ysyx_22050710_rf #(
    parameter int GPR_ADDR_WD     = 5,
    parameter int GPR_WD          = 64,
    parameter int CSR_ADDR_WD     = 12,
    parameter int CSR_WD          = 64,
    parameter int WS_TO_RF_BUS_WD = 147
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [WS_TO_RF_BUS_WD-1:0] i_ws_to_rf_bus,
    input  logic [GPR_ADDR_WD-1:0]     i_raddr1,
    input  logic [GPR_ADDR_WD-1:0]     i_raddr2,
    output logic [GPR_WD-1:0]          o_rdata1,
    output logic [GPR_WD-1:0]          o_rdata2,
    input  logic [CSR_ADDR_WD-1:0]     i_csr_raddr,
    output logic [CSR_WD-1:0]          o_csr_rdata,
    input  logic                       i_ecall,
    input  logic [CSR_WD-1:0]          i_epc,
    input  logic                       i_mret,
    output logic [CSR_WD-1:0]          o_mtvec,
    output logic [CSR_WD-1:0]          o_mepc
);
    localparam int GPR_NUM = 1 << GPR_ADDR_WD;

    localparam logic [CSR_ADDR_WD-1:0] ADDR_MSTATUS = CSR_ADDR_WD'(12'h300);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MTVEC   = CSR_ADDR_WD'(12'h305);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MEPC    = CSR_ADDR_WD'(12'h341);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MCAUSE  = CSR_ADDR_WD'(12'h342);

    localparam logic [CSR_WD-1:0] MSTATUS_RST = CSR_WD'(64'h1800);
    localparam logic [CSR_WD-1:0] CAUSE_ECALL = CSR_WD'(11);

    logic                   gpr_wen;
    logic [GPR_ADDR_WD-1:0] gpr_waddr;
    logic [GPR_WD-1:0]      gpr_wdata;
    logic                   csr_wen;
    logic [CSR_ADDR_WD-1:0] csr_waddr;
    logic [CSR_WD-1:0]      csr_wdata;

    assign {gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata} = i_ws_to_rf_bus;

    // x0 has no storage; reads of address 0 are forced to zero below.
    logic [GPR_WD-1:0] gpr_q [1:GPR_NUM-1];
    logic [GPR_WD-1:0] gpr_d [1:GPR_NUM-1];

    logic [CSR_WD-1:0] mstatus_q, mstatus_d;
    logic [CSR_WD-1:0] mtvec_q, mtvec_d;
    logic [CSR_WD-1:0] mepc_q, mepc_d;
    logic [CSR_WD-1:0] mcause_q, mcause_d;

    always_comb begin
        for (int i = 1; i < GPR_NUM; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (gpr_wen && (gpr_waddr != '0)) begin
            gpr_d[gpr_waddr] = gpr_wdata;
        end
    end

    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (csr_wen) begin
            case (csr_waddr)
                ADDR_MSTATUS: mstatus_d = csr_wdata;
                ADDR_MTVEC:   mtvec_d   = csr_wdata;
                ADDR_MEPC:    mepc_d    = csr_wdata;
                ADDR_MCAUSE:  mcause_d  = csr_wdata;
                default:      ;
            endcase
        end
        // Trap effects are applied last so they override any bus write to the same CSR.
        if (i_ecall) begin
            mepc_d          = i_epc;
            mcause_d        = CAUSE_ECALL;
            mstatus_d       = mstatus_q;
            mstatus_d[7]    = mstatus_q[3];
            mstatus_d[3]    = 1'b0;
            mstatus_d[12:11] = 2'b11;
        end else if (i_mret) begin
            mstatus_d       = mstatus_q;
            mstatus_d[3]    = mstatus_q[7];
            mstatus_d[7]    = 1'b1;
            mstatus_d[12:11] = 2'b11;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 1; i < GPR_NUM; i++) begin
                gpr_q[i] <= '0;
            end
            mstatus_q <= MSTATUS_RST;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            for (int i = 1; i < GPR_NUM; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    always_comb begin
        o_rdata1 = '0;
        if (i_raddr1 != '0) begin
            o_rdata1 = gpr_q[i_raddr1];
`ifdef YSYX_22050710_RF_BYPASS_EN
            if (gpr_wen && (gpr_waddr == i_raddr1)) o_rdata1 = gpr_wdata;
`endif
        end
    end

    always_comb begin
        o_rdata2 = '0;
        if (i_raddr2 != '0) begin
            o_rdata2 = gpr_q[i_raddr2];
`ifdef YSYX_22050710_RF_BYPASS_EN
            if (gpr_wen && (gpr_waddr == i_raddr2)) o_rdata2 = gpr_wdata;
`endif
        end
    end

`ifdef YSYX_22050710_RF_BYPASS_EN
    logic csr_waddr_hit;
    assign csr_waddr_hit = (csr_waddr == ADDR_MSTATUS) || (csr_waddr == ADDR_MTVEC) ||
                           (csr_waddr == ADDR_MEPC)    || (csr_waddr == ADDR_MCAUSE);
`endif

    always_comb begin
        case (i_csr_raddr)
            ADDR_MSTATUS: o_csr_rdata = mstatus_q;
            ADDR_MTVEC:   o_csr_rdata = mtvec_q;
            ADDR_MEPC:    o_csr_rdata = mepc_q;
            ADDR_MCAUSE:  o_csr_rdata = mcause_q;
            default:      o_csr_rdata = '0;
        endcase
`ifdef YSYX_22050710_RF_BYPASS_EN
        // Bus data only; trap updates are never forwarded.
        if (csr_wen && csr_waddr_hit && (csr_waddr == i_csr_raddr)) o_csr_rdata = csr_wdata;
`endif
    end

    assign o_mtvec = mtvec_q;
    assign o_mepc  = mepc_q;

endmodule

// File: tb/tb_ysyx_22050710_rf.sv
// Scoreboard bench for ysyx_22050710_rf: expected reads are queued when stimulus is driven
// and checked against the read ports once the write has landed.
module tb_ysyx_22050710_rf;
    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [146:0] i_ws_to_rf_bus;
    logic [4:0]   i_raddr1, i_raddr2;
    logic [63:0]  o_rdata1, o_rdata2;
    logic [11:0]  i_csr_raddr;
    logic [63:0]  o_csr_rdata;
    logic         i_ecall, i_mret;
    logic [63:0]  i_epc;
    logic [63:0]  o_mtvec, o_mepc;

    logic         gpr_wen;
    logic [4:0]   gpr_waddr;
    logic [63:0]  gpr_wdata;
    logic         csr_wen;
    logic [11:0]  csr_waddr;
    logic [63:0]  csr_wdata;

    assign i_ws_to_rf_bus = {gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata};

    ysyx_22050710_rf dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ws_to_rf_bus (i_ws_to_rf_bus),
        .i_raddr1       (i_raddr1),
        .i_raddr2       (i_raddr2),
        .o_rdata1       (o_rdata1),
        .o_rdata2       (o_rdata2),
        .i_csr_raddr    (i_csr_raddr),
        .o_csr_rdata    (o_csr_rdata),
        .i_ecall        (i_ecall),
        .i_epc          (i_epc),
        .i_mret         (i_mret),
        .o_mtvec        (o_mtvec),
        .o_mepc         (o_mepc)
    );

    always #5 i_clk = ~i_clk;

    // kind: 0 = port 1, 1 = port 2, 2 = CSR port, 3 = o_mtvec, 4 = o_mepc
    typedef struct {
        string       tag;
        int          kind;
        logic [11:0] addr;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    logic [63:0] gpr_m [32];

`ifdef YSYX_22050710_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int kind, input logic [11:0] addr,
                           input logic [63:0] exp);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        sb_t         e;
        logic [63:0] got;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       i_raddr1    = e.addr[4:0];
                1:       i_raddr2    = e.addr[4:0];
                2:       i_csr_raddr = e.addr;
                default: ;
            endcase
            #1;
            case (e.kind)
                0:       got = o_rdata1;
                1:       got = o_rdata2;
                2:       got = o_csr_rdata;
                3:       got = o_mtvec;
                default: got = o_mepc;
            endcase
            check_val(e.tag, got, e.exp);
        end
    endtask

    task automatic idle();
        gpr_wen = 1'b0; gpr_waddr = '0; gpr_wdata = '0;
        csr_wen = 1'b0; csr_waddr = '0; csr_wdata = '0;
        i_ecall = 1'b0; i_mret = 1'b0; i_epc = '0;
    endtask

    task automatic txn(input string what);
        n_txn++;
        $display("txn %0d: %s", n_txn, what);
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic push_csrs(input string tag, input logic [63:0] ms, input logic [63:0] tv,
                             input logic [63:0] ep, input logic [63:0] mc);
        sb_push({tag, "_mstatus"}, 2, 12'h300, ms);
        sb_push({tag, "_mtvec"},   2, 12'h305, tv);
        sb_push({tag, "_mepc"},    2, 12'h341, ep);
        sb_push({tag, "_mcause"},  2, 12'h342, mc);
        sb_push({tag, "_o_mtvec"}, 3, 12'h000, tv);
        sb_push({tag, "_o_mepc"},  4, 12'h000, ep);
    endtask

    task automatic push_all_gprs(input string tag);
        for (int r = 0; r < 32; r++) begin
            sb_push($sformatf("%s_x%0d_p1", tag, r), 0, 12'(r), gpr_m[r]);
            sb_push($sformatf("%s_x%0d_p2", tag, r), 1, 12'(r), gpr_m[r]);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) gpr_m[r] = '0;
        idle();
        i_rst = 1'b1; i_raddr1 = '0; i_raddr2 = '0; i_csr_raddr = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        $display("txn 0: reset released");
        push_all_gprs("rst");
        push_csrs("rst", 64'h1800, 64'h0, 64'h0, 64'h0);
        sb_drain();

        // GPR write with same-cycle read of the target
        @(negedge i_clk);
        gpr_wen = 1'b1; gpr_waddr = 5'd5; gpr_wdata = 64'hDEAD_BEEF; i_raddr1 = 5'd5;
        #1;
        check_val("x5_same_cycle", o_rdata1, BYPASS ? 64'hDEAD_BEEF : 64'h0);
        txn("write x5=0xDEADBEEF");
        gpr_m[5] = 64'hDEAD_BEEF;
        sb_push("x5_p1", 0, 12'd5, 64'hDEAD_BEEF);
        sb_push("x5_p2", 1, 12'd5, 64'hDEAD_BEEF);
        sb_drain();

        @(negedge i_clk);
        gpr_wen = 1'b1; gpr_waddr = 5'd0; gpr_wdata = 64'h1234; i_raddr2 = 5'd0;
        #1;
        check_val("x0_same_cycle", o_rdata2, 64'h0);
        txn("write x0=0x1234");
        sb_push("x0_p1", 0, 12'd0, 64'h0);
        sb_push("x0_p2", 1, 12'd0, 64'h0);
        sb_drain();

        for (int k = 0; k < 24; k++) begin
            @(negedge i_clk);
            gpr_wen   = ($urandom_range(0, 3) != 0);
            gpr_waddr = 5'($urandom_range(0, 31));
            gpr_wdata = {$urandom, $urandom};
            if (gpr_wen && gpr_waddr != 5'd0) gpr_m[gpr_waddr] = gpr_wdata;
            txn($sformatf("rand wen=%0d x%0d=0x%016h", gpr_wen, gpr_waddr, gpr_wdata));
        end
        push_all_gprs("rand");
        sb_drain();

        // CSR bus writes
        @(negedge i_clk);
        csr_wen = 1'b1; csr_waddr = 12'h305; csr_wdata = 64'h8000_0100; i_csr_raddr = 12'h305;
        #1;
        check_val("mtvec_same_cycle", o_csr_rdata, BYPASS ? 64'h8000_0100 : 64'h0);
        txn("write mtvec=0x80000100");
        push_csrs("mtvec_wr", 64'h1800, 64'h8000_0100, 64'h0, 64'h0);
        sb_drain();

        @(negedge i_clk);
        csr_wen = 1'b1; csr_waddr = 12'h7C0; csr_wdata = 64'hFFFF; i_csr_raddr = 12'h7C0;
        #1;
        check_val("csr7c0_same_cycle", o_csr_rdata, 64'h0);
        txn("write csr 0x7C0=0xFFFF");
        sb_push("csr7c0", 2, 12'h7C0, 64'h0);
        push_csrs("csr7c0", 64'h1800, 64'h8000_0100, 64'h0, 64'h0);
        sb_drain();

        // Traps
        @(negedge i_clk);
        csr_wen = 1'b1; csr_waddr = 12'h300; csr_wdata = 64'h1808;
        txn("write mstatus=0x1808");
        @(negedge i_clk);
        i_ecall = 1'b1; i_epc = 64'h8000_0040;
        txn("ecall epc=0x80000040");
        push_csrs("ecall", 64'h1880, 64'h8000_0100, 64'h8000_0040, 64'd11);
        sb_drain();

        @(negedge i_clk);
        csr_wen = 1'b1; csr_waddr = 12'h300; csr_wdata = 64'h1808;
        txn("write mstatus=0x1808");
        @(negedge i_clk);
        i_ecall = 1'b1; i_epc = 64'h8000_0040;
        csr_wen = 1'b1; csr_waddr = 12'h341; csr_wdata = 64'h55;
        txn("ecall with bus mepc=0x55");
        push_csrs("ecall_bus", 64'h1880, 64'h8000_0100, 64'h8000_0040, 64'd11);
        sb_drain();

        @(negedge i_clk);
        i_mret = 1'b1;
        txn("mret");
        push_csrs("mret", 64'h1888, 64'h8000_0100, 64'h8000_0040, 64'd11);
        sb_drain();

        @(negedge i_clk);
        i_mret = 1'b1;
        csr_wen = 1'b1; csr_waddr = 12'h341; csr_wdata = 64'h77;
        txn("mret with bus mepc=0x77");
        push_csrs("mret_bus", 64'h1888, 64'h8000_0100, 64'h77, 64'd11);
        sb_drain();

        @(negedge i_clk);
        i_ecall = 1'b1; i_mret = 1'b1; i_epc = 64'h90;
        txn("ecall and mret together");
        push_csrs("ecall_mret", 64'h1880, 64'h8000_0100, 64'h90, 64'd11);
        sb_drain();

        @(negedge i_clk);
        i_ecall = 1'b1; i_epc = 64'hA0;
        csr_wen = 1'b1; csr_waddr = 12'h305; csr_wdata = 64'h200;
        txn("ecall with bus mtvec=0x200");
        push_csrs("ecall_mtvec", 64'h1800, 64'h200, 64'hA0, 64'd11);
        sb_drain();

        @(negedge i_clk);
        i_mret = 1'b1;
        csr_wen = 1'b1; csr_waddr = 12'h342; csr_wdata = 64'h5;
        txn("mret with bus mcause=0x5");
        push_csrs("mret_mcause", 64'h1880, 64'h200, 64'hA0, 64'h5);
        sb_drain();

        // Reset wins over a same-cycle write
        @(negedge i_clk);
        gpr_wen = 1'b1; gpr_waddr = 5'd3; gpr_wdata = 64'h7;
        txn("write x3=7");
        gpr_m[3] = 64'h7;
        sb_push("x3_pre", 0, 12'd3, 64'h7);
        sb_drain();
        @(negedge i_clk);
        i_rst = 1'b1;
        gpr_wen = 1'b1; gpr_waddr = 5'd3; gpr_wdata = 64'h99;
        i_ecall = 1'b1; i_epc = 64'h1234;
        txn("reset with write x3 and ecall");
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int r = 0; r < 32; r++) gpr_m[r] = '0;
        push_all_gprs("rst2");
        push_csrs("rst2", 64'h1800, 64'h0, 64'h0, 64'h0);
        sb_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
